// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with 2-FF column sync and frame debounce.
// Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
module keypad_scanner #(
    parameter int SETTLE_CYCLES  = 64,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 16
) (
    input  logic       clk_48,
    input  logic       reset,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] buttons,
    output logic       key_held
);

    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam int MAXC = (DEBOUNCE_SCANS > REPEAT_SCANS) ?
                          DEBOUNCE_SCANS : REPEAT_SCANS;
    localparam int CW = $clog2(MAXC + 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    pressed;
    logic [SW-1:0] slot;
    logic [1:0]    row;
    logic [15:0]   snapshot;
    logic          frame_done;
    logic          last_slot;

    assign pressed   = ~sync2;
    assign last_slot = (slot == SW'(SETTLE_CYCLES - 1));

    always_comb begin
        row_n = ~(4'b0001 << row);
    end

    always_ff @(posedge clk_48 or posedge reset) begin
        if (reset) begin
            sync1      <= 4'hF;
            sync2      <= 4'hF;
            slot       <= '0;
            row        <= '0;
            snapshot   <= '0;
            frame_done <= 1'b0;
        end else begin
            sync1      <= col_n;
            sync2      <= sync1;
            frame_done <= 1'b0;
            if (last_slot) begin
                slot                         <= '0;
                snapshot[{row, 2'b00} +: 4]  <= pressed;
                row                          <= row + 2'd1;
                frame_done                   <= (row == 2'd3);
            end else begin
                slot <= slot + SW'(1);
            end
        end
    end

    // Key 0 is reserved: masked out before counting.
    logic [15:0] valid;
    logic [3:0]  hits;
    logic [3:0]  key_idx;
    logic        none;
    logic        single;

    always_comb begin
        valid   = snapshot & 16'hFFFE;
        hits    = '0;
        key_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (valid[i]) begin
                hits    = hits + 4'd1;
                key_idx = 4'(i);
            end
        end
        none   = (hits == 4'd0);
        single = (hits == 4'd1);
    end

    state_t        state;
    logic [3:0]    cand;
    logic [CW-1:0] cnt;
`ifdef KEYPAD_REPEAT_EN
    logic [CW-1:0] rpt;
`endif

    always_ff @(posedge clk_48 or posedge reset) begin
        if (reset) begin
            state    <= RELEASED;
            cand     <= '0;
            cnt      <= '0;
            buttons  <= '0;
            key_held <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt      <= '0;
`endif
        end else begin
            buttons <= '0;
            if (frame_done) begin
`ifdef KEYPAD_REPEAT_EN
                rpt <= '0;
`endif
                unique case (state)
                    RELEASED: begin
                        if (single) begin
                            cand  <= key_idx;
                            cnt   <= CW'(1);
                            state <= PRESS_WAIT;
                        end
                    end
                    PRESS_WAIT: begin
                        if (single && key_idx == cand) begin
                            if (cnt == CW'(DEBOUNCE_SCANS - 1)) begin
                                state    <= HELD;
                                key_held <= 1'b1;
                                buttons  <= cand;
                                cnt      <= '0;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end else if (single) begin
                            cand <= key_idx;
                            cnt  <= CW'(1);
                        end else begin
                            state <= RELEASED;
                            cnt   <= '0;
                        end
                    end
                    HELD: begin
                        if (none) begin
                            state <= RELEASE_WAIT;
                            cnt   <= CW'(1);
                        end
`ifdef KEYPAD_REPEAT_EN
                        // Mute toggles, so it must never auto-repeat.
                        else if (single && key_idx == cand &&
                                 cand != 4'd7) begin
                            if (rpt == CW'(REPEAT_SCANS - 1)) begin
                                buttons <= cand;
                            end else begin
                                rpt <= rpt + CW'(1);
                            end
                        end
`endif
                    end
                    RELEASE_WAIT: begin
                        if (none) begin
                            if (cnt == CW'(DEBOUNCE_SCANS - 1)) begin
                                state    <= RELEASED;
                                key_held <= 1'b0;
                                cnt      <= '0;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end else begin
                            state <= HELD;
                            cnt   <= '0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad model.
// SETTLE_CYCLES=8, DEBOUNCE_SCANS=4, REPEAT_SCANS=8: one frame = 32 cycles.
module tb_keypad_scanner;

    logic        clk_48 = 1'b0;
    logic        reset  = 1'b1;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [3:0]  buttons;
    logic        key_held;
    logic [15:0] keys = '0;

    int checks = 0;
    int passed = 0;
    int cyc;
    int pcyc[$];
    int pval[$];
    logic held_seen = 1'b0;

    keypad_scanner #(
        .SETTLE_CYCLES (8),
        .DEBOUNCE_SCANS(4),
        .REPEAT_SCANS  (8)
    ) dut (
        .clk_48  (clk_48),
        .reset   (reset),
        .col_n   (col_n),
        .row_n   (row_n),
        .buttons (buttons),
        .key_held(key_held)
    );

    always #5 clk_48 = ~clk_48;

    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row_n[r] && keys[4*r+c]) col_n[c] = 1'b0;
    end

    always @(posedge clk_48 or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clk_48) begin
        if (!reset && buttons != 4'd0) begin
            pcyc.push_back(cyc);
            pval.push_back(int'(buttons));
        end
        if (key_held) held_seen = 1'b1;
    end

    task automatic wait_cyc(input int t);
        int guard = 0;
        while (cyc < t && guard < 20000) begin
            @(negedge clk_48);
            guard++;
        end
        checks++;
        if (cyc != t) $display("FAIL wait_cyc: cyc=%0d required %0d", cyc, t);
        else passed++;
    endtask

    task automatic do_reset(input logic [15:0] k);
        @(negedge clk_48);
        reset = 1'b1;
        keys  = k;
        repeat (2) @(negedge clk_48);
        pcyc.delete();
        pval.delete();
        held_seen = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        logic [3:0] exp_row;
        do_reset(16'h0000);
        keys = 16'h0200;
        wait_cyc(32 * 5 + 10);
        @(posedge clk_48);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (row_n !== 4'b1110) $display("FAIL rst_row: got %b want 1110", row_n);
        else passed++;
        checks++;
        if (buttons !== 4'd0) $display("FAIL rst_buttons: got %0d want 0", buttons);
        else passed++;
        checks++;
        if (key_held !== 1'b0) $display("FAIL rst_held: got %b want 0", key_held);
        else passed++;
        keys = 16'h0000;
        @(negedge clk_48);
        @(negedge clk_48);
        pcyc.delete();
        pval.delete();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_cyc(8 * i + 4);
            exp_row = ~(4'b0001 << (i % 4));
            checks++;
            if (row_n !== exp_row)
                $display("FAIL row_walk%0d: got %b want %b", i, row_n, exp_row);
            else passed++;
        end
    endtask

    task automatic test_clean_press;
        do_reset(16'h0200);
        wait_cyc(128);
        checks++;
        if (buttons !== 4'd0) $display("FAIL k9_early: got %0d want 0", buttons);
        else passed++;
        wait_cyc(129);
        checks++;
        if (buttons !== 4'd9) $display("FAIL k9_pulse: got %0d want 9", buttons);
        else passed++;
        checks++;
        if (key_held !== 1'b1) $display("FAIL k9_held: got %b want 1", key_held);
        else passed++;
        wait_cyc(130);
        checks++;
        if (buttons !== 4'd0) $display("FAIL k9_width: got %0d want 0", buttons);
        else passed++;
        wait_cyc(32 * 24);
`ifndef KEYPAD_REPEAT_EN
        checks++;
        if (pcyc.size() != 1)
            $display("FAIL k9_count: got %0d pulses want 1", pcyc.size());
        else passed++;
`endif
        keys = 16'h0000;
        wait_cyc(896);
        checks++;
        if (key_held !== 1'b1) $display("FAIL k9_rel_early: got %b want 1", key_held);
        else passed++;
        wait_cyc(897);
        checks++;
        if (key_held !== 1'b0) $display("FAIL k9_released: got %b want 0", key_held);
        else passed++;
    endtask

    task automatic test_bounce;
        do_reset(16'h0020);
        wait_cyc(32);
        keys = 16'h0000;
        wait_cyc(64);
        keys = 16'h0020;
        wait_cyc(192);
        checks++;
        if (pcyc.size() != 0)
            $display("FAIL bounce_early: got %0d pulses want 0", pcyc.size());
        else passed++;
        wait_cyc(193);
        checks++;
        if (buttons !== 4'd5) $display("FAIL bounce_pulse: got %0d want 5", buttons);
        else passed++;
        wait_cyc(320);
        checks++;
        if (pcyc.size() != 1)
            $display("FAIL bounce_count: got %0d pulses want 1", pcyc.size());
        else passed++;
    endtask

    task automatic test_multi;
        do_reset(16'h0804);
        wait_cyc(320);
        checks++;
        if (pcyc.size() != 0)
            $display("FAIL multi_pulse: got %0d pulses want 0", pcyc.size());
        else passed++;
        checks++;
        if (held_seen !== 1'b0) $display("FAIL multi_held: got %b want 0", held_seen);
        else passed++;
        keys = 16'h0001;
        wait_cyc(640);
        checks++;
        if (pcyc.size() != 0)
            $display("FAIL key0_pulse: got %0d pulses want 0", pcyc.size());
        else passed++;
        checks++;
        if (held_seen !== 1'b0) $display("FAIL key0_held: got %b want 0", held_seen);
        else passed++;
    endtask

    task automatic test_rollover;
        do_reset(16'h0010);
        wait_cyc(129);
        checks++;
        if (buttons !== 4'd4) $display("FAIL roll_k4: got %0d want 4", buttons);
        else passed++;
        wait_cyc(192);
        keys = 16'h0050;
        wait_cyc(384);
        keys = 16'h0000;
        wait_cyc(576);
        checks++;
        if (pcyc.size() != 1)
            $display("FAIL roll_count: got %0d pulses want 1", pcyc.size());
        else passed++;
        checks++;
        if (key_held !== 1'b0) $display("FAIL roll_held: got %b want 0", key_held);
        else passed++;
        keys = 16'h0040;
        wait_cyc(705);
        checks++;
        if (buttons !== 4'd6) $display("FAIL roll_k6: got %0d want 6", buttons);
        else passed++;
        wait_cyc(736);
        checks++;
        if (pcyc.size() != 2)
            $display("FAIL roll_total: got %0d pulses want 2", pcyc.size());
        else passed++;
    endtask

    task automatic test_reset_press_wait;
        do_reset(16'h0200);
        wait_cyc(70);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (buttons !== 4'd0 || key_held !== 1'b0)
            $display("FAIL pw_rst: got %0d/%b want 0/0", buttons, key_held);
        else passed++;
        @(negedge clk_48);
        pcyc.delete();
        pval.delete();
        reset = 1'b0;
        wait_cyc(128);
        checks++;
        if (pcyc.size() != 0)
            $display("FAIL pw_early: got %0d pulses want 0", pcyc.size());
        else passed++;
        wait_cyc(129);
        checks++;
        if (buttons !== 4'd9) $display("FAIL pw_pulse: got %0d want 9", buttons);
        else passed++;
    endtask

`ifdef KEYPAD_REPEAT_EN
    task automatic test_repeat;
        do_reset(16'h0008);
        wait_cyc(129);
        checks++;
        if (buttons !== 4'd3) $display("FAIL rep_first: got %0d want 3", buttons);
        else passed++;
        wait_cyc(385);
        checks++;
        if (buttons !== 4'd3) $display("FAIL rep_second: got %0d want 3", buttons);
        else passed++;
        wait_cyc(641);
        checks++;
        if (buttons !== 4'd3) $display("FAIL rep_third: got %0d want 3", buttons);
        else passed++;
        wait_cyc(650);
        checks++;
        if (pcyc.size() != 3)
            $display("FAIL rep_count: got %0d pulses want 3", pcyc.size());
        else passed++;
        do_reset(16'h0080);
        wait_cyc(32 * 30);
        checks++;
        if (pcyc.size() != 1)
            $display("FAIL mute_count: got %0d pulses want 1", pcyc.size());
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_multi();
        test_rollover();
        test_reset_press_wait();
`ifdef KEYPAD_REPEAT_EN
        test_repeat();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 active-low matrix keypad, synchronizes and debounces it, and emits one 4-bit key code per accepted press.
- Feeds the button-code input of the channel-strip control encoder. Code 0 means "no event".
- Every code other than 0 is a one-cycle pulse, so a held key never retriggers a toggling function such as mute (code 7).

Parameters:
- SETTLE_CYCLES, 64: clk_48 cycles each row is driven before its columns are sampled. Must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical full-matrix frames required to accept a press or a release. Must be >= 2.
- REPEAT_SCANS, 16: frames between auto-repeat pulses. Used only when KEYPAD_REPEAT_EN is defined.

Ports:
- clk_48  input  1  system clock
- reset  input  1  asynchronous reset, active-high
- col_n  input  4  keypad columns, active-low, externally pulled up, asynchronous
- row_n  output  4  keypad row drive, exactly one bit low at any time
- buttons  output  4  key code pulse; 0 when idle
- key_held  output  1  debounced "a key is down" status

Behaviour:
- Reset values: row_n=4'b1110; buttons=0; key_held=0; all counters=0; debounce FSM=RELEASED; frame snapshot cleared.
- col_n passes through a 2-FF synchronizer. pressed = ~synchronized col_n.
- Scan timing:
  - Row index r runs 0..3, then wraps to 0. row_n[r]=0 and all other bits are 1.
  - A slot counter runs 0..SETTLE_CYCLES-1 for each row.
  - On the last slot cycle: snapshot[4r+c] <= pressed[c] for c=0..3, then advance r.
  - Frame period = 4*SETTLE_CYCLES cycles.
  - After row 3 is sampled, frame_done pulses for one cycle and the frame is classified in that cycle.
- Frame classification (key index k = 4*row+col):
  - Bit 0 is reserved and always ignored.
  - NONE: no bits set in 1..15.
  - SINGLE(k): exactly one bit set in 1..15.
  - MULTI: two or more bits set in 1..15.
- Debounce FSM (evaluated only on frame_done). cand = candidate key, cnt = consecutive-frame counter.
  - RELEASED:
    - SINGLE(k) -> cand=k, cnt=1, go to PRESS_WAIT.
    - Otherwise stay.
  - PRESS_WAIT:
    - SINGLE(cand) -> cnt++. When cnt reaches DEBOUNCE_SCANS -> go to HELD and emit cand.
    - SINGLE(other) -> cand=other, cnt=1.
    - NONE or MULTI -> go to RELEASED, cnt=0.
  - HELD:
    - NONE -> go to RELEASE_WAIT, cnt=1.
    - SINGLE(any) or MULTI -> stay. No new emission, no roll-over.
  - RELEASE_WAIT:
    - NONE -> cnt++. When cnt reaches DEBOUNCE_SCANS -> go to RELEASED, cnt=0.
    - Anything else -> go to HELD, cnt=0.
- Emission:
  - buttons=cand for exactly one cycle: the cycle after the frame_done that completes acceptance.
  - buttons=0 at all other times.
  - Latency from the first clean frame containing the key = (DEBOUNCE_SCANS-1) frames + 1 cycle after that first frame's frame_done.
- key_held=1 in HELD and RELEASE_WAIT, and 0 otherwise. It updates in the same cycle as the FSM transition.
- A new press is accepted only after a full debounced release.
- Asynchronous reset at any point aborts the scan and FSM and returns to reset values. No partial emission.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined (auto-repeat):
  - In HELD, a repeat counter counts SINGLE(cand) frames.
  - Each time it reaches REPEAT_SCANS, it re-emits cand as a one-cycle pulse and clears.
  - MULTI, NONE, or leaving HELD clears the counter.
  - cand=7 (mute) never repeats.
- Undefined: no repeat logic is present. Exactly one pulse per debounced press.

Test Plan (SETTLE_CYCLES=8, DEBOUNCE_SCANS=4, REPEAT_SCANS=8, frame = 32 cycles):
- Reset: assert reset mid-frame -> row_n=1110, buttons=0, key_held=0 immediately. After release, row_n walks 1110, 1101, 1011, 0111 every 8 cycles.
- Clean press of key 9 (row 2, col 1):
  - buttons=9 for one cycle, one cycle after the 4th matching frame_done. key_held=1 in that cycle.
  - Holding 20 frames gives no further pulses (macro off).
  - After release, key_held=0 after 4 NONE frames.
- Bounce on key 5 (pressed/released on alternate frames for 3 frames, then stable) -> a single buttons=5 pulse after 4 stable frames, and no earlier pulse.
- Keys 2 and 11 held together -> buttons stays 0 and key_held stays 0. Key at (0,0) alone -> buttons stays 0.
- Press key 4, then add key 6 while held, then release both -> exactly one pulse (4) and no pulse for 6. Pressing 6 after a full release -> pulse 6.
- With KEYPAD_REPEAT_EN, hold key 3 -> pulses at acceptance, then every 8 frames. Hold key 7 -> exactly one pulse.
- Reset asserted during PRESS_WAIT (after 2 matching frames) -> no pulse. After reset release, 4 new matching frames are needed.
